// File: rtl/seq_player.sv
// Sequence game engine: grows a random 2-bit symbol sequence one round at a time,
// plays it out for display, then checks the player's presses against it.
module seq_player #(
   parameter int MAX_LEN    = 16,
   parameter int ON_CYCLES  = 8,
   parameter int OFF_CYCLES = 4,
   localparam int LW = $clog2(MAX_LEN + 1)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [1:0]    RAND,
   input  logic          START,
   input  logic          BTN_VALID,
   input  logic [1:0]    BTN,
   output logic          SHOW_VALID,
   output logic [1:0]    SHOW,
   output logic [LW-1:0] LEVEL,
   output logic          BUSY,
   output logic          WIN,
   output logic          FAIL
);

   localparam int IW     = $clog2(MAX_LEN);
   localparam int PH_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int CW     = $clog2(PH_MAX + 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_APPEND   = 3'd1;
   localparam logic [2:0] S_SHOW_ON  = 3'd2;
   localparam logic [2:0] S_SHOW_OFF = 3'd3;
   localparam logic [2:0] S_WAIT_IN  = 3'd4;
   localparam logic [2:0] S_WIN      = 3'd5;
   localparam logic [2:0] S_FAIL     = 3'd6;

   logic [2:0]    state, state_nxt;
   logic [LW-1:0] len, len_nxt;
   logic [IW-1:0] idx, idx_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          wr_en;
   logic [1:0]    sym_nxt;
   logic          last;
   logic [1:0]    mem [MAX_LEN];

   assign last  = (LW'(idx) == len - LW'(1));
   assign LEVEL = len;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_nxt = state;
      len_nxt   = len;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      wr_en     = 1'b0;
      if (START) begin
         state_nxt = S_APPEND;
         len_nxt   = '0;
         idx_nxt   = '0;
         cnt_nxt   = '0;
      end else begin
         case (state)
            S_APPEND: begin
               wr_en     = 1'b1;
               len_nxt   = len + LW'(1);
               idx_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = S_SHOW_ON;
            end
            S_SHOW_ON: begin
               if (cnt == CW'(ON_CYCLES - 1)) begin
                  cnt_nxt   = '0;
                  state_nxt = S_SHOW_OFF;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            S_SHOW_OFF: begin
               if (cnt == CW'(OFF_CYCLES - 1)) begin
                  cnt_nxt = '0;
                  if (last) begin
                     idx_nxt   = '0;
                     state_nxt = S_WAIT_IN;
                  end else begin
                     idx_nxt   = idx + IW'(1);
                     state_nxt = S_SHOW_ON;
                  end
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            S_WAIT_IN: begin
               if (BTN_VALID) begin
                  if (BTN != mem[idx]) begin
                     state_nxt = S_FAIL;
                  end else if (!last) begin
                     idx_nxt = idx + IW'(1);
                  end else if (len == LW'(MAX_LEN)) begin
                     state_nxt = S_WIN;
                  end else begin
                     state_nxt = S_APPEND;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // A symbol written this edge can be the one displayed next cycle, so bypass it.
   assign sym_nxt = (wr_en && IW'(len) == idx_nxt) ? RAND : mem[idx_nxt];

   // NOTE: the sequence memory has no reset; contents are only ever read after being written.
   always_ff @(posedge CLK) begin
      if (wr_en) mem[IW'(len)] <= RAND;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= S_IDLE;
         len        <= '0;
         idx        <= '0;
         cnt        <= '0;
         SHOW_VALID <= 1'b0;
         SHOW       <= '0;
         BUSY       <= 1'b0;
         WIN        <= 1'b0;
         FAIL       <= 1'b0;
      end else begin
         state      <= state_nxt;
         len        <= len_nxt;
         idx        <= idx_nxt;
         cnt        <= cnt_nxt;
         SHOW_VALID <= (state_nxt == S_SHOW_ON);
         SHOW       <= (state_nxt == S_SHOW_ON) ? sym_nxt : 2'd0;
         BUSY       <= (state_nxt == S_APPEND) || (state_nxt == S_SHOW_ON) ||
                       (state_nxt == S_SHOW_OFF) || (state_nxt == S_WAIT_IN);
         WIN        <= (state_nxt == S_WIN);
         FAIL       <= (state_nxt == S_FAIL);
      end
   end

endmodule

// File: tb/tb_seq_player.sv
// Bench for seq_player: directed game scenarios plus random games, every cycle
// compared against a round/timeline model of the game.
module tb_seq_player;

   localparam int MAX_LEN = 2;
   localparam int ON      = 2;
   localparam int OFF     = 1;
   localparam int P       = ON + OFF;
   localparam int LW      = $clog2(MAX_LEN + 1);

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [1:0]    RAND = '0;
   logic          START = 1'b0;
   logic          BTN_VALID = 1'b0;
   logic [1:0]    BTN = '0;
   logic          SHOW_VALID;
   logic [1:0]    SHOW;
   logic [LW-1:0] LEVEL;
   logic          BUSY;
   logic          WIN;
   logic          FAIL;

   seq_player #(.MAX_LEN(MAX_LEN), .ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
      .CLK(CLK), .RST(RST), .RAND(RAND), .START(START), .BTN_VALID(BTN_VALID),
      .BTN(BTN), .SHOW_VALID(SHOW_VALID), .SHOW(SHOW), .LEVEL(LEVEL),
      .BUSY(BUSY), .WIN(WIN), .FAIL(FAIL)
   );

   always #5 CLK = ~CLK;

   typedef enum {M_IDLE, M_APPEND, M_PLAY, M_WAIT, M_WON, M_LOST} mode_t;

   mode_t      mode = M_IDLE;
   int         mlen = 0;
   int         pidx = 0;
   int         t    = 0;
   logic [1:0] seq [MAX_LEN];
   int         n_vec = 0;
   int         n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Game rules: a round appends one symbol, plays the whole sequence as a
   // timeline of P-cycle slots (ON shown, OFF blank), then awaits presses.
   task automatic model_step();
      if (RST) begin
         mode = M_IDLE;
         mlen = 0;
      end else if (START) begin
         mode = M_APPEND;
         mlen = 0;
         pidx = 0;
      end else begin
         case (mode)
            M_APPEND: begin
               seq[mlen] = RAND;
               mlen++;
               t    = 0;
               mode = M_PLAY;
            end
            M_PLAY: begin
               t++;
               if (t == mlen * P) begin
                  mode = M_WAIT;
                  pidx = 0;
               end
            end
            M_WAIT: begin
               if (BTN_VALID) begin
                  if (BTN != seq[pidx]) mode = M_LOST;
                  else if (pidx == mlen - 1) mode = (mlen == MAX_LEN) ? M_WON : M_APPEND;
                  else pidx++;
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic compare();
      logic       exp_sv;
      logic [1:0] exp_show;
      exp_sv   = (mode == M_PLAY) && ((t % P) < ON);
      exp_show = exp_sv ? seq[t / P] : 2'd0;
      check("show_valid", 32'(SHOW_VALID), 32'(exp_sv));
      check("show", 32'(SHOW), 32'(exp_show));
      check("level", 32'(LEVEL), 32'(mlen));
      check("busy", 32'(BUSY), 32'((mode == M_APPEND) || (mode == M_PLAY) || (mode == M_WAIT)));
      check("win", 32'(WIN), 32'(mode == M_WON));
      check("lose", 32'(FAIL), 32'(mode == M_LOST));
   endtask

   // Inputs are stable from the previous falling edge; outputs are compared at the falling edge.
   task automatic tick();
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      compare();
      START     = 1'b0;
      BTN_VALID = 1'b0;
      BTN       = 2'($urandom);
      RAND      = 2'($urandom);
   endtask

   task automatic start_game(input logic [1:0] sym);
      START = 1'b1;
      tick();
      RAND = sym;
      tick();
   endtask

   task automatic press(input logic [1:0] sym);
      BTN_VALID = 1'b1;
      BTN       = sym;
      tick();
   endtask

   task automatic wait_mode(input mode_t target, input int budget);
      int n = 0;
      while (mode != target && n < budget) begin
         tick();
         n++;
      end
      check("reach_mode", 32'(mode == target), 32'd1);
   endtask

   initial begin
      // Reset and quiet idle
      tick();
      tick();
      RST = 1'b0;
      repeat (4) tick();

      // First round: symbol 3 shown for ON cycles, then blank, then WAIT
      start_game(2'd3);
      wait_mode(M_WAIT, 20);
      repeat (3) tick();

      // Asynchronous reset mid-playback
      start_game(2'd1);
      tick();
      RST = 1'b1;
      #1;
      mode = M_IDLE;
      mlen = 0;
      compare();
      tick();
      RST = 1'b0;
      repeat (5) tick();

      // Win: round 1 shows 1, round 2 shows 1 then 2
      start_game(2'd1);
      wait_mode(M_WAIT, 20);
      press(2'd1);
      RAND = 2'd2;
      tick();
      wait_mode(M_WAIT, 20);
      press(2'd1);
      press(2'd2);
      repeat (3) tick();
      check("win_level", 32'(LEVEL), 32'd2);

      // Fail on a wrong press; later presses ignored
      start_game(2'd1);
      wait_mode(M_WAIT, 20);
      press(2'd0);
      press(2'd1);
      press(2'd0);
      repeat (2) tick();

      // Restart out of the failed state
      start_game(2'd2);
      check("restart_level", 32'(LEVEL), 32'd1);

      // Press during SHOW_ON ignored; START beats a simultaneous wrong press
      press(2'd0);
      wait_mode(M_WAIT, 20);
      START     = 1'b1;
      BTN_VALID = 1'b1;
      BTN       = ~seq[0];
      tick();
      RAND = 2'd0;
      tick();
      check("prio_level", 32'(LEVEL), 32'd1);
      wait_mode(M_WAIT, 20);

      // Random games with stray presses and occasional restarts
      for (int g = 0; g < 60; g++) begin
         START = 1'b1;
         tick();
         for (int c = 0; c < 200 && mode != M_WON && mode != M_LOST; c++) begin
            if (mode == M_WAIT && $urandom_range(2) == 0) begin
               BTN_VALID = 1'b1;
               BTN = ($urandom_range(99) < 85) ? seq[pidx] : 2'($urandom);
            end else if ($urandom_range(9) == 0) begin
               BTN_VALID = 1'b1;
            end
            if ($urandom_range(99) == 0) START = 1'b1;
            tick();
         end
         repeat ($urandom_range(3)) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seq_player.md
# seq_player

Game-sequence engine that consumes the 2-bit random symbol stream from the free-running random number generator. On each round it appends one sampled symbol to a stored sequence, plays the full sequence out for display, then checks the player's button presses against it. It sits between the random source and the display and button front ends, and reports level, win and fail status to the top level.

## Interface

Parameters:
- MAX_LEN, 16: maximum sequence length (rounds to win); 2..64.
- ON_CYCLES, 8: cycles each symbol is shown (≥1).
- OFF_CYCLES, 4: blank cycles after each symbol (≥1).

Ports:
- CLK  input  1  clock.
- RST  input  1  asynchronous, active-high reset.
- RAND  input  2  random symbol; sampled only in APPEND.
- START  input  1  one-cycle pulse: begin a new game; honored in every state.
- BTN_VALID  input  1  one-cycle pulse: player pressed BTN.
- BTN  input  2  pressed symbol; valid with BTN_VALID.
- SHOW_VALID  output  1  display symbol now.
- SHOW  output  2  symbol to display; 0 when SHOW_VALID=0.
- LEVEL  output  $clog2(MAX_LEN+1)  current sequence length.
- BUSY  output  1  high in APPEND, SHOW_ON, SHOW_OFF, WAIT_IN.
- WIN  output  1  high in WIN state.
- FAIL  output  1  high in FAIL state.

## Operation

- Storage: MAX_LEN x 2-bit sequence memory, length register LEN, index IDX, phase counter.
- States: IDLE, APPEND, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, FAIL.
- IDLE: outputs quiet; waits for START.
- START (any state, including mid-playback or mid-input): LEN<=0, IDX<=0, next state APPEND. Memory contents are not cleared.
- APPEND (exactly one cycle): mem[LEN]<=RAND, LEN<=LEN+1, IDX<=0, next SHOW_ON.
- SHOW_ON: SHOW_VALID=1, SHOW=mem[IDX] for ON_CYCLES cycles, then SHOW_OFF.
- SHOW_OFF: SHOW_VALID=0 for OFF_CYCLES cycles; then if IDX==LEN-1: IDX<=0, go WAIT_IN; else IDX<=IDX+1, go SHOW_ON.
- WAIT_IN: on BTN_VALID:
  - If BTN==mem[IDX] and IDX<LEN-1: IDX<=IDX+1.
  - If BTN==mem[IDX] and IDX==LEN-1: go WIN if LEN==MAX_LEN, else go APPEND.
  - If BTN!=mem[IDX]: go FAIL.
- No input timeout: WAIT_IN holds indefinitely.
- BTN_VALID is ignored in every state except WAIT_IN.
- WIN/FAIL: held until START or RST. LEVEL keeps its final value.
- START and BTN_VALID in the same cycle: START wins; the press is dropped.
- LEVEL never exceeds MAX_LEN. LEN and IDX never wrap.

## Timing

- All outputs are registered and derived from the current state.
- Reset values: SHOW_VALID=0, SHOW=0, LEVEL=0, BUSY=0, WIN=0, FAIL=0; state IDLE.
- RST asserted mid-operation returns the block to IDLE immediately, asynchronously.
- START sampled at edge k: APPEND is active in cycle k..k+1, and RAND is sampled at edge k+1.
- LEVEL increments at the edge that ends APPEND.
- The first SHOW_VALID cycle follows APPEND directly.
- Round of length L: playback takes L·(ON_CYCLES+OFF_CYCLES) cycles, then WAIT_IN.
- Correct final press sampled at edge m: next round's APPEND is active in cycle m..m+1 (one-cycle turnaround).
- WIN or FAIL asserts in the cycle after the deciding press.
- BUSY drops in the same cycle that WIN or FAIL rises.

## Test plan

All scenarios use MAX_LEN=2, ON_CYCLES=2, OFF_CYCLES=1.

- Reset: assert RST mid-playback. Required: all outputs 0 and state IDLE at once; after release, no activity without START.
- First round: RAND=2'd3, pulse START. Required: BUSY=1; LEVEL=1 after APPEND; SHOW_VALID=1 with SHOW=3 for exactly 2 cycles; then 1 blank cycle; then WAIT_IN.
- Win: round 1 with RAND=1, press BTN=1; round 2 with RAND=2. Required: playback shows 1 then 2. Pressing 1 then 2 gives WIN=1, BUSY=0, LEVEL=2.
- Fail: after round-1 playback of symbol 1, press BTN=0. Required: FAIL=1 next cycle, LEVEL stays 1, later presses ignored.
- Ignored and priority inputs: pulse BTN_VALID during SHOW_ON. Required: no effect. Then pulse START together with BTN_VALID in WAIT_IN. Required: restart, LEVEL=1 after APPEND, no FAIL.
- Restart from WIN/FAIL: pulse START while FAIL=1. Required: FAIL drops, APPEND follows, LEVEL=1.
